// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-pipeline types: 2-bit PHT counter encodings, reset state and resolved-branch record.
// No state and no timing; only types and pure helper functions.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        PHT_SNT = 2'b00,
        PHT_WNT = 2'b01,
        PHT_WT  = 2'b10,
        PHT_ST  = 2'b11
    } pht_state_e;

    localparam pht_state_e PHT_RESET  = PHT_WNT;
    localparam logic [63:0] INSN_BYTES = 64'd4;

    typedef struct packed {
        logic        valid;
        logic        is_branch;
        logic        taken;
        logic [63:0] pc;
        logic [63:0] target;
        logic [63:0] pred_next_pc;
    } ex_res_t;

    // Saturating step toward the resolved direction.
    function automatic pht_state_e pht_next(input pht_state_e cur, input logic taken);
        pht_state_e nxt;
        case (cur)
            PHT_SNT: nxt = taken ? PHT_WNT : PHT_SNT;
            PHT_WNT: nxt = taken ? PHT_WT  : PHT_SNT;
            PHT_WT:  nxt = taken ? PHT_ST  : PHT_WNT;
            default: nxt = taken ? PHT_ST  : PHT_WT;
        endcase
        return nxt;
    endfunction

    function automatic logic pht_taken(input pht_state_e s);
        return s[1];
    endfunction

endpackage

// File: rtl/fetch_pc_unit_pht_2bit.sv
// Pattern history table of 2-bit saturating counters; combinational read, write on clk edge.
// Read returns the pre-update value on a same-index collision; no backpressure, write always accepted.
module pht_2bit
    import fetch_pc_unit_pkg::*;
#(
    parameter int LOWER = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LOWER-1:0] rd_addr,
    output pht_state_e       rd_state,
    input  logic             wr_en,
    input  logic [LOWER-1:0] wr_addr,
    input  logic             wr_taken
);

    localparam int ENTRIES = 1 << LOWER;

    pht_state_e tbl [ENTRIES];

    assign rd_state = tbl[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i] <= PHT_RESET;
            end
        end else if (wr_en) begin
            tbl[wr_addr] <= pht_next(tbl[wr_addr], wr_taken);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generation with BTB/PHT prediction and execute-stage mispredict redirect; zero-cycle prediction.
// No backpressure: en=0 stalls the PC, but redirects and PHT training proceed regardless.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int          LOWER    = 5,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             btb_hit,
    input  logic [63:0]      btb_target,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [63:0]      ex_pc,
    input  logic [63:0]      ex_target,
    input  logic [63:0]      ex_pred_next_pc,
    output logic [63:0]      pc,
    output logic [63:0]      pred_next_pc,
    output logic [LOWER-1:0] btb_read_addr,
    output logic [LOWER-1:0] btb_write_addr,
    output logic             btb_was_taken,
    output logic             btb_write_en,
    output logic             flush,
    output logic [31:0]      branch_count,
    output logic [31:0]      mispredict_count
);

    ex_res_t     ex;
    pht_state_e  rd_state;
    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic [63:0] actual_next;
    logic        pred_taken;
    logic        mispredict;
    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    assign ex = '{
        valid:        ex_valid,
        is_branch:    ex_is_branch,
        taken:        ex_taken,
        pc:           ex_pc,
        target:       ex_target,
        pred_next_pc: ex_pred_next_pc
    };

    assign btb_read_addr  = pc_q[LOWER+1:2];
    assign btb_write_addr = ex.pc[LOWER+1:2];
    assign btb_write_en   = ex.valid & ex.is_branch;
    assign btb_was_taken  = ex.taken;

    pht_2bit #(
        .LOWER (LOWER)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (btb_read_addr),
        .rd_state (rd_state),
        .wr_en    (btb_write_en),
        .wr_addr  (btb_write_addr),
        .wr_taken (ex.taken)
    );

    assign pred_taken   = btb_hit & pht_taken(rd_state);
    assign pred_next_pc = pred_taken ? btb_target : pc_q + INSN_BYTES;

    // Compare full next-PC rather than direction so a wrong BTB target also redirects.
    assign actual_next = ex.taken ? ex.target : ex.pc + INSN_BYTES;
    assign mispredict  = btb_write_en & (actual_next != ex.pred_next_pc);
    assign flush       = mispredict;

    always_comb begin
        pc_d = pc_q;
        if (mispredict) begin
            pc_d = actual_next;
        end else if (en) begin
            pc_d = pred_next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q               <= RESET_PC;
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            pc_q               <= pc_d;
            branch_count_q     <= branch_count_q + {31'd0, btb_write_en};
            mispredict_count_q <= mispredict_count_q + {31'd0, mispredict};
        end
    end

    assign pc               = pc_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: driver pushes model expectations, monitor pops and compares each cycle.
module tb_fetch_pc_unit;

    localparam int LOWER = 5;
    localparam int N     = 1 << LOWER;

    logic             clk = 1'b0;
    logic             rst, en, btb_hit, ex_valid, ex_is_branch, ex_taken;
    logic [63:0]      btb_target, ex_pc, ex_target, ex_pred_next_pc;
    logic [63:0]      pc, pred_next_pc;
    logic [LOWER-1:0] btb_read_addr, btb_write_addr;
    logic             btb_was_taken, btb_write_en, flush;
    logic [31:0]      branch_count, mispredict_count;

    always #5 clk = ~clk;

    fetch_pc_unit #(
        .LOWER    (LOWER),
        .RESET_PC (64'h0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .btb_hit          (btb_hit),
        .btb_target       (btb_target),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_taken         (ex_taken),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_pred_next_pc  (ex_pred_next_pc),
        .pc               (pc),
        .pred_next_pc     (pred_next_pc),
        .btb_read_addr    (btb_read_addr),
        .btb_write_addr   (btb_write_addr),
        .btb_was_taken    (btb_was_taken),
        .btb_write_en     (btb_write_en),
        .flush            (flush),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] pred;
        logic        flush;
        logic        wen;
        logic        was_taken;
        int          ridx;
        int          widx;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;

    // Reference model state: fetch address, counter table as plain ints, event counts.
    logic [63:0] m_pc;
    int          m_pht[N];
    logic [31:0] m_bc, m_mc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic h, input logic [63:0] tgt,
                        input logic xv, input logic xb, input logic xt,
                        input logic [63:0] xpc, input logic [63:0] xtgt, input logic [63:0] xpred);
        exp_t        x;
        int          ri, wi;
        logic        ptk, wen, misp;
        logic [63:0] pred, actual;
        @(negedge clk);
        rst = r; en = e; btb_hit = h; btb_target = tgt;
        ex_valid = xv; ex_is_branch = xb; ex_taken = xt;
        ex_pc = xpc; ex_target = xtgt; ex_pred_next_pc = xpred;

        ri     = int'((m_pc / 64'd4) % 64'(N));
        wi     = int'((xpc / 64'd4) % 64'(N));
        ptk    = h && (m_pht[ri] >= 2);
        pred   = ptk ? tgt : m_pc + 64'd4;
        actual = xt ? xtgt : xpc + 64'd4;
        wen    = xv && xb;
        misp   = wen && (actual != xpred);

        if (!r) begin
            x = '{pc: m_pc, pred: pred, flush: misp, wen: wen, was_taken: xt,
                  ridx: ri, widx: wi, bc: m_bc, mc: m_mc};
            exp_q.push_back(x);
        end

        if (r) begin
            m_pc = 64'h0;
            for (int i = 0; i < N; i++) m_pht[i] = 1;
            m_bc = 32'd0;
            m_mc = 32'd0;
        end else begin
            if (misp)   m_pc = actual;
            else if (e) m_pc = pred;
            if (wen) begin
                if (xt) m_pht[wi] = (m_pht[wi] == 3) ? 3 : m_pht[wi] + 1;
                else    m_pht[wi] = (m_pht[wi] == 0) ? 0 : m_pht[wi] - 1;
                m_bc = m_bc + 32'd1;
            end
            if (misp) m_mc = m_mc + 32'd1;
        end
    endtask

    task automatic fetch(input logic e, input logic h, input logic [63:0] tgt);
        step(1'b0, e, h, tgt, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    endtask

    task automatic resolve(input logic e, input logic xt, input logic [63:0] xpc,
                           input logic [63:0] xtgt, input logic [63:0] xpred);
        step(1'b0, e, 1'b0, 64'h0, 1'b1, 1'b1, xt, xpc, xtgt, xpred);
    endtask

    // Monitor: every cycle that has an expectation is compared after outputs settle.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("pc",           pc,                     x.pc);
                check("pred_next_pc", pred_next_pc,           x.pred);
                check("flush",        64'(flush),             64'(x.flush));
                check("write_en",     64'(btb_write_en),      64'(x.wen));
                check("was_taken",    64'(btb_was_taken),     64'(x.was_taken));
                check("read_addr",    64'(btb_read_addr),     64'(x.ridx));
                check("write_addr",   64'(btb_write_addr),    64'(x.widx));
                check("branch_count", 64'(branch_count),      64'(x.bc));
                check("misp_count",   64'(mispredict_count),  64'(x.mc));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic        e, h, xv, xb, xt;
        logic [63:0] tgt, xpc, xtgt, xpred;
        int          guard;

        rst = 1'b1; en = 1'b1; btb_hit = 1'b0; btb_target = 64'h0;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0;
        ex_pc = 64'h0; ex_target = 64'h0; ex_pred_next_pc = 64'h0;
        m_pc = 64'h0; m_bc = 32'd0; m_mc = 32'd0;
        for (int i = 0; i < N; i++) m_pht[i] = 1;

        // Reset held two cycles with en=1.
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        check("rst_pc",   pc,                    64'h0);
        check("rst_pred", pred_next_pc,          64'h4);
        check("rst_bc",   64'(branch_count),     64'h0);
        check("rst_mc",   64'(mispredict_count), 64'h0);
        for (int i = 0; i < N; i++) check("rst_pht", 64'(dut.u_pht.tbl[i]), 64'd1);

        // Sequential fetch.
        for (int i = 0; i < 4; i++) fetch(1'b1, 1'b0, 64'h0);
        @(posedge clk);
        #1;
        check("seq_pc", pc, 64'h10);

        // Training at 0x40, then predict from it.
        resolve(1'b1, 1'b1, 64'h40, 64'h100, 64'h100);
        resolve(1'b1, 1'b1, 64'h40, 64'h100, 64'h100);
        guard = 0;
        while (m_pc != 64'h40 && guard < 100) begin
            fetch(1'b1, 1'b0, 64'h0);
            guard++;
        end
        fetch(1'b1, 1'b1, 64'h100);
        resolve(1'b0, 1'b1, 64'h40, 64'h100, 64'h100);
        @(posedge clk);
        #1;
        check("train_pc",  pc,                       64'h100);
        check("pht16_sat", 64'(dut.u_pht.tbl[16]),   64'd3);

        // Mispredict while stalled.
        resolve(1'b0, 1'b0, 64'h40, 64'h100, 64'h100);
        @(posedge clk);
        #1;
        check("misp_pc", pc,                          64'h44);
        check("misp_mc", 64'(mispredict_count),       64'(m_mc));

        // Redirect to 0x40, then read and update index 16 in the same cycle.
        resolve(1'b0, 1'b0, 64'h3C, 64'h0, 64'h0);
        step(1'b0, 1'b0, 1'b1, 64'h100, 1'b1, 1'b1, 1'b0, 64'h40, 64'h0, 64'h44);
        fetch(1'b0, 1'b1, 64'h100);
        @(posedge clk);
        #1;
        check("coll_pht16", 64'(dut.u_pht.tbl[16]), 64'd1);

        // Branch count wrap.
        fetch(1'b0, 1'b0, 64'h0);
        #3;
        force dut.branch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.branch_count_q;
        m_bc = 32'hFFFF_FFFF;
        resolve(1'b0, 1'b1, 64'h80, 64'h200, 64'h200);
        @(posedge clk);
        #1;
        check("bc_wrap", 64'(branch_count), 64'h0);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            e     = ($urandom_range(0, 3) != 0);
            h     = ($urandom_range(0, 1) != 0);
            tgt   = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                 : {32'h0, $urandom_range(0, 255), 2'b00};
            xv    = ($urandom_range(0, 2) != 0);
            xb    = ($urandom_range(0, 3) != 0);
            xt    = ($urandom_range(0, 1) != 0);
            xpc   = 64'($urandom_range(0, 63)) * 64'd4;
            xtgt  = {32'h0, $urandom_range(0, 255), 2'b00};
            xpred = ($urandom_range(0, 1) != 0) ? (xt ? xtgt : xpc + 64'd4)
                                                : {$urandom, $urandom};
            step(($urandom_range(0, 99) == 0), e, h, tgt, xv, xb, xt, xpc, xtgt, xpred);
        end

        @(negedge clk);
        #5;
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
